branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Execute-stage companion to the one-bit dynamic branch predictor. It carries each fetched instruction's prediction (taken flag and target) through the F/D and D/E pipeline registers. In E it evaluates the real branch/jump outcome from forwarded operands and raises `mispredict` with the redirect PC. It also drives the predictor's training inputs and keeps saturating branch/mispredict counters.

## Interface
Parameters:
- `DATA_WIDTH`, 32, datapath and PC width
- `CNT_WIDTH`, 32, width of each performance counter

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `PC_f`  in  DATA_WIDTH  PC of the instruction in F
- `RD_f`  in  32  instruction word in F
- `predict_taken_f`  in  1  predictor's taken flag for `PC_f`
- `branch_target_f`  in  DATA_WIDTH  predictor's target for `PC_f`
- `stall_d`  in  1  hazard stall: F/D holds, D/E loads a bubble
- `rs1_e`, `rs2_e`  in  DATA_WIDTH each  forwarded operands of the E instruction
- `mispredict`  out  1  E-stage control instruction was mispredicted (combinational)
- `branch_actual_taken`  out  1  E instruction is control and actually taken
- `branch_actual_target`  out  DATA_WIDTH  computed taken-target of the E instruction
- `redirect_pc_e`  out  DATA_WIDTH  next fetch PC on mispredict
- `flush_d`  out  1  equals `mispredict`; tells fetch to discard F
- `branch_count`  out  CNT_WIDTH  resolved control instructions
- `mispredict_count`  out  CNT_WIDTH  resolved mispredicts

## Operation
- Two register stages. F/D and D/E each hold {valid, PC, instr, pred_taken, pred_target}.
- Edge priority for F/D: `rst`, then `mispredict` (load valid=0), then `stall_d` (hold), else load F values with valid=1.
- Edge priority for D/E: `rst`, then `mispredict` or `stall_d` (load valid=0), else copy F/D.
- Control class decoded in E from opcode:
  - 1100011 = BRANCH
  - 1101111 = JAL
  - 1100111 = JALR
  - any other opcode = non-control
- Immediates are sign-extended: B-type for BRANCH, J-type for JAL, I-type for JALR.
- Branch conditions by funct3:
  - 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU
  - 010 and 011 are never taken
- Actual target:
  - BRANCH and JAL: PC_e + imm
  - JALR: (rs1_e + imm) with bit0 cleared
  - All additions are modulo 2^DATA_WIDTH.
- `branch_actual_taken` = valid_e & control & (JAL | JALR | condition true). It is 0 otherwise.
- `branch_actual_target` shows the computed target whenever E holds a valid control instruction, and 0 otherwise.
- `mispredict` = valid_e & control & ((actual_taken ≠ pred_taken) | (actual_taken & pred_target ≠ actual_target)).
- `redirect_pc_e` = actual_taken ? actual_target : PC_e + 4. It is 0 when `mispredict` = 0.
- Counters, on each edge with valid_e & control:
  - `branch_count` increments.
  - `mispredict_count` increments if `mispredict`.
  - Both saturate at all-ones and never wrap.
- A non-control instruction with pred_taken=1 is not flagged. The front end must not let that case occur.

## Timing
- On reset:
  - All valid bits, counters and stored fields are 0.
  - All outputs read 0, including `mispredict`, `flush_d`, `branch_actual_taken`, `branch_actual_target` and `redirect_pc_e`.
- Reset asserted mid-operation clears everything immediately. No mispredict is reported for the instruction that was in flight.
- Latency: an instruction sampled in F at edge N reaches E after edge N+1, assuming no stall. Its outputs are valid combinationally during that cycle.
- `mispredict` lasts exactly one cycle per mispredicted instruction. The flush on the next edge removes the E instruction, so it cannot repeat.
- `mispredict` together with `stall_d` in the same cycle: flush wins and both registers load bubbles.
- Back-to-back control instructions resolve one per cycle. A mispredict squashes the younger instruction, so it is never evaluated.

## Test plan
- BEQ at PC 0x100, imm +0x20, rs1=rs2=5, pred_taken=0:
  - `mispredict`=1, `branch_actual_taken`=1, `redirect_pc_e`=0x120 in E.
  - Next edge: both registers flushed, `mispredict_count`=1.
- BNE at 0x200, rs1=rs2, pred_taken=0 → no mispredict, `branch_actual_taken`=0, `branch_count`+1.
- BLT with rs1=0xFFFFFFFF, rs2=1 → taken; BLTU with the same operands → not taken. Each is checked against the pred bit supplied.
- JAL at 0x300, imm +0x40, pred_taken=1:
  - pred_target=0x340 → no mispredict.
  - pred_target=0x344 → `mispredict`=1, `redirect_pc_e`=0x340.
- JALR with rs1=0x1003, imm=+4, pred_taken=0 → target 0x1006, `mispredict`=1.
- Cross-cases:
  - `stall_d`=1 in the same cycle as a mispredict → both registers hold valid=0 after the edge.
  - Counter preset to all-ones stays all-ones after another branch.
  - `rst` pulse mid-stream zeroes every output asynchronously.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolution for a one-bit dynamic predictor front end.
// The F/D and D/E registers carry each instruction's prediction (taken flag and
// target) alongside its PC and instruction word. In E the real control-flow
// outcome is computed from forwarded operands and compared with the prediction.
// On a mismatch the unit raises a redirect and flushes both younger stages.
// It also keeps saturating counters of resolved control instructions and of
// mispredicts.
module branch_resolve_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] PC_f,
    input  logic [31:0]           RD_f,
    input  logic                  predict_taken_f,
    input  logic [DATA_WIDTH-1:0] branch_target_f,
    input  logic                  stall_d,
    input  logic [DATA_WIDTH-1:0] rs1_e,
    input  logic [DATA_WIDTH-1:0] rs2_e,
    output logic                  mispredict,
    output logic                  branch_actual_taken,
    output logic [DATA_WIDTH-1:0] branch_actual_target,
    output logic [DATA_WIDTH-1:0] redirect_pc_e,
    output logic                  flush_d,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // ------------------------------------------------------------------
    // F/D pipeline register
    // ------------------------------------------------------------------
    logic                  fd_valid_q, fd_valid_d;
    logic [DATA_WIDTH-1:0] fd_pc_q, fd_pc_d;
    logic [31:0]           fd_instr_q, fd_instr_d;
    logic                  fd_pred_taken_q, fd_pred_taken_d;
    logic [DATA_WIDTH-1:0] fd_pred_target_q, fd_pred_target_d;

    // ------------------------------------------------------------------
    // D/E pipeline register
    // ------------------------------------------------------------------
    logic                  de_valid_q, de_valid_d;
    logic [DATA_WIDTH-1:0] de_pc_q, de_pc_d;
    logic [31:0]           de_instr_q, de_instr_d;
    logic                  de_pred_taken_q, de_pred_taken_d;
    logic [DATA_WIDTH-1:0] de_pred_target_q, de_pred_target_d;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0]  branch_count_q, branch_count_d;
    logic [CNT_WIDTH-1:0]  mispredict_count_q, mispredict_count_d;

    // ------------------------------------------------------------------
    // E-stage decode and resolution signals
    // ------------------------------------------------------------------
    logic [6:0]            opcode_e;
    logic [2:0]            funct3_e;
    logic                  is_branch_e, is_jal_e, is_jalr_e, is_ctrl_e;
    logic                  ctrl_valid_e;
    logic [DATA_WIDTH-1:0] imm_b_e, imm_j_e, imm_i_e, imm_e;
    logic [DATA_WIDTH-1:0] target_base_e, target_sum_e, target_e;
    logic                  cond_e;
    logic                  taken_e;
    logic                  mispredict_e;

    // F/D next state: a flush beats a stall, a stall holds, otherwise load F.
    always_comb begin
        fd_valid_d       = fd_valid_q;
        fd_pc_d          = fd_pc_q;
        fd_instr_d       = fd_instr_q;
        fd_pred_taken_d  = fd_pred_taken_q;
        fd_pred_target_d = fd_pred_target_q;
        if (mispredict_e) begin
            fd_valid_d = 1'b0;
        end else if (!stall_d) begin
            fd_valid_d       = 1'b1;
            fd_pc_d          = PC_f;
            fd_instr_d       = RD_f;
            fd_pred_taken_d  = predict_taken_f;
            fd_pred_target_d = branch_target_f;
        end
    end

    // D/E next state: flush or stall inserts a bubble, otherwise advance F/D.
    always_comb begin
        de_valid_d       = fd_valid_q;
        de_pc_d          = fd_pc_q;
        de_instr_d       = fd_instr_q;
        de_pred_taken_d  = fd_pred_taken_q;
        de_pred_target_d = fd_pred_target_q;
        if (mispredict_e || stall_d) begin
            de_valid_d = 1'b0;
        end
    end

    // Pipeline register state; asynchronous reset clears every field.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fd_valid_q       <= 1'b0;
            fd_pc_q          <= '0;
            fd_instr_q       <= '0;
            fd_pred_taken_q  <= 1'b0;
            fd_pred_target_q <= '0;
            de_valid_q       <= 1'b0;
            de_pc_q          <= '0;
            de_instr_q       <= '0;
            de_pred_taken_q  <= 1'b0;
            de_pred_target_q <= '0;
        end else begin
            fd_valid_q       <= fd_valid_d;
            fd_pc_q          <= fd_pc_d;
            fd_instr_q       <= fd_instr_d;
            fd_pred_taken_q  <= fd_pred_taken_d;
            fd_pred_target_q <= fd_pred_target_d;
            de_valid_q       <= de_valid_d;
            de_pc_q          <= de_pc_d;
            de_instr_q       <= de_instr_d;
            de_pred_taken_q  <= de_pred_taken_d;
            de_pred_target_q <= de_pred_target_d;
        end
    end

    // Decode the E instruction's control class and sign-extended immediates.
    always_comb begin
        opcode_e    = de_instr_q[6:0];
        funct3_e    = de_instr_q[14:12];
        is_branch_e = (opcode_e == OP_BRANCH);
        is_jal_e    = (opcode_e == OP_JAL);
        is_jalr_e   = (opcode_e == OP_JALR);
        is_ctrl_e   = is_branch_e | is_jal_e | is_jalr_e;
        ctrl_valid_e = de_valid_q & is_ctrl_e;

        imm_b_e = {{(DATA_WIDTH-13){de_instr_q[31]}}, de_instr_q[31], de_instr_q[7],
                   de_instr_q[30:25], de_instr_q[11:8], 1'b0};
        imm_j_e = {{(DATA_WIDTH-21){de_instr_q[31]}}, de_instr_q[31], de_instr_q[19:12],
                   de_instr_q[20], de_instr_q[30:21], 1'b0};
        imm_i_e = {{(DATA_WIDTH-12){de_instr_q[31]}}, de_instr_q[31:20]};

        if (is_jal_e) begin
            imm_e = imm_j_e;
        end else if (is_jalr_e) begin
            imm_e = imm_i_e;
        end else begin
            imm_e = imm_b_e;
        end
    end

    // Compute the taken-target; JALR is register-relative with bit 0 forced low.
    always_comb begin
        target_base_e = is_jalr_e ? rs1_e : de_pc_q;
        target_sum_e  = target_base_e + imm_e;
        target_e      = is_jalr_e ? {target_sum_e[DATA_WIDTH-1:1], 1'b0} : target_sum_e;
    end

    // Evaluate the conditional-branch comparison selected by funct3.
    always_comb begin
        cond_e = 1'b0;
        case (funct3_e)
            3'b000:  cond_e = (rs1_e == rs2_e);
            3'b001:  cond_e = (rs1_e != rs2_e);
            3'b100:  cond_e = ($signed(rs1_e) <  $signed(rs2_e));
            3'b101:  cond_e = ($signed(rs1_e) >= $signed(rs2_e));
            3'b110:  cond_e = (rs1_e <  rs2_e);
            3'b111:  cond_e = (rs1_e >= rs2_e);
            default: cond_e = 1'b0;   // 010/011 have no branch meaning
        endcase
    end

    // Compare the actual outcome with the carried prediction.
    always_comb begin
        taken_e      = ctrl_valid_e & (is_jal_e | is_jalr_e | (is_branch_e & cond_e));
        // A non-control instruction is never flagged, even if predicted taken.
        mispredict_e = ctrl_valid_e &
                       ((taken_e != de_pred_taken_q) |
                        (taken_e & (de_pred_target_q != target_e)));
    end

    // Saturating counters advance once per resolved control instruction.
    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (ctrl_valid_e) begin
            if (branch_count_q != {CNT_WIDTH{1'b1}}) begin
                branch_count_d = branch_count_q + CNT_WIDTH'(1);
            end
            if (mispredict_e && (mispredict_count_q != {CNT_WIDTH{1'b1}})) begin
                mispredict_count_d = mispredict_count_q + CNT_WIDTH'(1);
            end
        end
    end

    // Counter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // Drive outputs; targets and redirects read zero when not meaningful.
    always_comb begin
        mispredict           = mispredict_e;
        flush_d              = mispredict_e;
        branch_actual_taken  = taken_e;
        branch_actual_target = ctrl_valid_e ? target_e : '0;
        redirect_pc_e        = '0;
        if (mispredict_e) begin
            redirect_pc_e = taken_e ? target_e : (de_pc_q + DATA_WIDTH'(4));
        end
        branch_count     = branch_count_q;
        mispredict_count = mispredict_count_q;
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit. Counters are narrowed to 4 bits so
// saturation can be reached in a short run.
module tb_branch_resolve_unit;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] PC_f;
    logic [31:0]   RD_f;
    logic          predict_taken_f;
    logic [DW-1:0] branch_target_f;
    logic          stall_d;
    logic [DW-1:0] rs1_e, rs2_e;
    logic          mispredict, branch_actual_taken, flush_d;
    logic [DW-1:0] branch_actual_target, redirect_pc_e;
    logic [CW-1:0] branch_count, mispredict_count;

    int total_checks  = 0;
    int passed_checks = 0;

    branch_resolve_unit #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .PC_f                 (PC_f),
        .RD_f                 (RD_f),
        .predict_taken_f      (predict_taken_f),
        .branch_target_f      (branch_target_f),
        .stall_d              (stall_d),
        .rs1_e                (rs1_e),
        .rs2_e                (rs2_e),
        .mispredict           (mispredict),
        .branch_actual_taken  (branch_actual_taken),
        .branch_actual_target (branch_actual_target),
        .redirect_pc_e        (redirect_pc_e),
        .flush_d              (flush_d),
        .branch_count         (branch_count),
        .mispredict_count     (mispredict_count)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm);
        return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in F, then a NOP behind it; on return it sits in E.
    task automatic issue(input logic [31:0] pc, input logic [31:0] instr,
                         input logic pt, input logic [31:0] ptgt);
        PC_f = pc; RD_f = instr; predict_taken_f = pt; branch_target_f = ptgt;
        step();
        PC_f = 32'h0; RD_f = NOP; predict_taken_f = 1'b0; branch_target_f = 32'h0;
        step();
        $display("txn pc=%h instr=%h pt=%0d ptgt=%h -> misp=%0d taken=%0d tgt=%h redir=%h",
                 pc, instr, pt, ptgt, mispredict, branch_actual_taken,
                 branch_actual_target, redirect_pc_e);
    endtask

    task automatic chk_out(input string tag, input logic m, input logic t,
                           input logic [31:0] tgt, input logic [31:0] rd);
        chk({tag, ".misp"},   32'(mispredict), 32'(m));
        chk({tag, ".flush"},  32'(flush_d), 32'(m));
        chk({tag, ".taken"},  32'(branch_actual_taken), 32'(t));
        chk({tag, ".target"}, branch_actual_target, tgt);
        chk({tag, ".redir"},  redirect_pc_e, rd);
    endtask

    task automatic chk_cnt(input string tag, input int bc, input int mc);
        chk({tag, ".bcnt"}, 32'(branch_count), bc);
        chk({tag, ".mcnt"}, 32'(mispredict_count), mc);
    endtask

    initial begin
        rst = 1'b1; PC_f = '0; RD_f = NOP; predict_taken_f = 1'b0;
        branch_target_f = '0; stall_d = 1'b0; rs1_e = '0; rs2_e = '0;
        step();
        step();
        chk_out("reset", 1'b0, 1'b0, 32'h0, 32'h0);
        chk_cnt("reset", 0, 0);
        #2 rst = 1'b0;

        // BEQ taken but predicted not-taken
        rs1_e = 32'd5; rs2_e = 32'd5;
        issue(32'h100, enc_b(13'h020, 3'b000), 1'b0, 32'h0);
        chk_out("beq", 1'b1, 1'b1, 32'h120, 32'h120);
        step();
        chk("beq.fd_flushed", 32'(dut.fd_valid_q), 32'd0);
        chk("beq.de_flushed", 32'(dut.de_valid_q), 32'd0);
        chk("beq.after_misp", 32'(mispredict), 32'd0);
        chk_cnt("beq", 1, 1);

        // BNE not taken, predicted not-taken
        rs1_e = 32'd7; rs2_e = 32'd7;
        issue(32'h200, enc_b(13'h010, 3'b001), 1'b0, 32'h0);
        chk_out("bne", 1'b0, 1'b0, 32'h210, 32'h0);
        step();
        chk_cnt("bne", 2, 1);

        // BLT signed: -1 < 1 taken, correctly predicted
        rs1_e = 32'hFFFF_FFFF; rs2_e = 32'd1;
        issue(32'h240, enc_b(13'h008, 3'b100), 1'b1, 32'h248);
        chk_out("blt", 1'b0, 1'b1, 32'h248, 32'h0);
        step();
        chk_cnt("blt", 3, 1);

        // BLTU unsigned: 0xFFFFFFFF < 1 false, predicted taken
        issue(32'h260, enc_b(13'h008, 3'b110), 1'b1, 32'h268);
        chk_out("bltu", 1'b1, 1'b0, 32'h268, 32'h264);
        step();
        chk_cnt("bltu", 4, 2);

        // JAL correctly predicted
        issue(32'h300, enc_j(21'h00040), 1'b1, 32'h340);
        chk_out("jal_ok", 1'b0, 1'b1, 32'h340, 32'h0);
        step();
        chk_cnt("jal_ok", 5, 2);

        // JAL with wrong predicted target
        issue(32'h300, enc_j(21'h00040), 1'b1, 32'h344);
        chk_out("jal_bad", 1'b1, 1'b1, 32'h340, 32'h340);
        step();
        chk_cnt("jal_bad", 6, 3);

        // JALR: (0x1003 + 4) with bit 0 cleared
        rs1_e = 32'h1003;
        issue(32'h400, enc_i(12'h004), 1'b0, 32'h0);
        chk_out("jalr", 1'b1, 1'b1, 32'h1006, 32'h1006);
        step();
        chk_cnt("jalr", 7, 4);

        // funct3 010 is never taken
        rs1_e = 32'd3; rs2_e = 32'd3;
        issue(32'h440, enc_b(13'h010, 3'b010), 1'b0, 32'h0);
        chk_out("f3_010", 1'b0, 1'b0, 32'h450, 32'h0);
        step();
        chk_cnt("f3_010", 8, 4);

        // Non-control instruction predicted taken is not flagged or counted
        issue(32'h480, NOP, 1'b1, 32'h999);
        chk_out("nonctrl", 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk_cnt("nonctrl", 8, 4);

        // Stall in the same cycle as a mispredict: flush wins
        rs1_e = 32'd9; rs2_e = 32'd9;
        issue(32'h500, enc_b(13'h020, 3'b000), 1'b0, 32'h0);
        stall_d = 1'b1;
        #1;
        chk("stall_misp.misp", 32'(mispredict), 32'd1);
        step();
        stall_d = 1'b0;
        chk("stall_misp.fd_valid", 32'(dut.fd_valid_q), 32'd0);
        chk("stall_misp.de_valid", 32'(dut.de_valid_q), 32'd0);
        chk_cnt("stall_misp", 9, 5);

        // Asynchronous reset mid-stream while a mispredict is in E
        issue(32'h540, enc_b(13'h020, 3'b000), 1'b0, 32'h0);
        chk("rst_mid.pre", 32'(mispredict), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_out("rst_mid", 1'b0, 1'b0, 32'h0, 32'h0);
        chk_cnt("rst_mid", 0, 0);
        #1 rst = 1'b0;

        // Drive counters to saturation with mispredicting BEQs
        for (int k = 0; k < 15; k++) begin
            issue(32'h600, enc_b(13'h020, 3'b000), 1'b0, 32'h0);
            step();
        end
        chk_cnt("sat_reach", 15, 15);
        issue(32'h600, enc_b(13'h020, 3'b000), 1'b0, 32'h0);
        chk("sat.misp", 32'(mispredict), 32'd1);
        step();
        chk_cnt("sat_hold", 15, 15);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
